spi_mem_arbiter: RTL and testbench
==================================

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clk cycles per sclk half-period (>=1).
REQ-002 SHALL have parameter CS_SETUP, default 4, clk cycles cs low before first sclk rise.
REQ-003 SHALL have parameter CS_HOLD, default 4, clk cycles cs held low after last sclk fall.
REQ-004 clk  in  1  clock; all logic on posedge clk only.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 if_req  in  1  instruction-fetch request; held until if_done.
REQ-007 if_addr  in  24  fetch byte address.
REQ-008 if_rdata  out  32  fetch data; valid in the if_done cycle.
REQ-009 if_done  out  1  one-cycle fetch completion pulse.
REQ-010 ls_req  in  1  load/store request; held until ls_done.
REQ-011 ls_we  in  1  1 = write, 0 = read.
REQ-012 ls_addr  in  24  load/store byte address.
REQ-013 ls_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes.
REQ-014 ls_wdata  in  32  write data, byte 0 = bits [7:0].
REQ-015 ls_rdata  out  32  read data; valid in the ls_done cycle.
REQ-016 ls_done  out  1  one-cycle load/store completion pulse.
REQ-017 busy  out  1  high from grant until done pulse inclusive.
REQ-018 sclk / mosi / cs  out  1 each; miso  in  1  SPI mode-0 bus.

Function
REQ-019 FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE; IDLE->CS_SETUP on any req; CS_SETUP->SHIFT after CS_SETUP cycles; SHIFT->CS_HOLD after last bit; CS_HOLD->DONE after CS_HOLD cycles; DONE->IDLE unconditionally.
REQ-020 Arbitration in IDLE only: single requester granted; both requesting -> grant the port not granted last (round-robin); last_grant resets to fetch, so the first tie goes to ls.
REQ-021 Address, command, size, wdata and port id SHALL be latched at grant; input changes afterwards are ignored.
REQ-022 Frame, MSB first: 8-bit command (0x03 read, 0x02 write), 24-bit address, then 8*N data bits; N = 4 for fetch, per ls_size for ls.
REQ-023 Data bytes SHALL go little-endian: first data byte on wire <-> bits [7:0].
REQ-024 Mode 0: sclk idle low; mosi updated on sclk falling edge (first bit valid on SHIFT entry); miso sampled on sclk rising edge.
REQ-025 Write transactions: miso ignored; rdata of that port unchanged.
REQ-026 Read with N<4: unused upper rdata bytes SHALL be zero.
REQ-027 cs low throughout CS_SETUP, SHIFT, CS_HOLD; high in IDLE and DONE, giving >=2 cycles cs high between frames.
REQ-028 Latency: done pulses exactly 1 + CS_SETUP + (32+8N)*2*CLK_DIV + CS_HOLD cycles after the IDLE cycle that grants; fetch at defaults = 265.
REQ-029 Exactly one done pulse per grant, on the granted port only; req deasserted mid-frame does not abort.
REQ-030 Request still high in the DONE cycle is not re-granted; re-grant only from IDLE.

Reset
REQ-031 On rst_n low, at any state, next edge: state IDLE, cs=1, sclk=0, mosi=0, busy=0, both done=0, both rdata=0, last_grant=fetch; aborted frame SHALL NOT produce done.

Structure
REQ-032 Package spi_mem_pkg SHALL hold state enum, command constants (0x03/0x02), ls_size encoding, and port-id enum.
REQ-033 Sub-module spi_shifter SHALL hold the divider, bit counter, tx/rx shift registers; arbiter/FSM stays in spi_mem_arbiter.

Verification
REQ-034 Fetch if_addr=0x000100, model returns 0x11,0x22,0x33,0x44 -> mosi 0x03 0x00 0x01 0x00, if_rdata=0x44332211, if_done at cycle 265.
REQ-035 ls write, size=0, addr=0x00ABCD, wdata=0xDEADBEEF -> 40 bits 0x02 0x00 0xAB 0xCD 0xEF, ls_done only, if_rdata unchanged.
REQ-036 ls read, size=1, model returns 0x5A,0xA5 -> ls_rdata=0x0000A55A, done at 1+4+192+4=201.
REQ-037 if_req and ls_req raised same cycle, held -> order ls, if, ls; cs high >=2 cycles between frames.
REQ-038 rst_n low mid-SHIFT -> cs=1, sclk=0 next cycle, no done pulse; fresh fetch after reset completes normally.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared types and helpers for the SPI memory arbiter: FSM states, port ids,
// load/store size encoding, SPI command bytes and data-lane reordering.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_DONE
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_LS    = 1'b1
    } port_t;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'd0,
        SIZE_HALF     = 2'd1,
        SIZE_WORD     = 2'd2,
        SIZE_WORD_ALT = 2'd3
    } ls_size_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam int         FRAME_W   = 64;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (ls_size_t'(size))
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    // The receive register holds wire-order bytes in its low lanes; flip them
    // so the first byte on the wire lands in bits [7:0] and unused lanes are zero.
    function automatic logic [31:0] rx_to_le(input logic [31:0] rx, input logic [2:0] nbytes);
        case (nbytes)
            3'd1:    return {24'h0, rx[7:0]};
            3'd2:    return {16'h0, rx[7:0], rx[15:8]};
            default: return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        endcase
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-0 bit engine: sclk divider, bit counter, MSB-first transmit shift
// register and receive shift register. Frame contents are loaded by the arbiter.
module spi_shifter
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               shift_en,
    input  logic [FRAME_W-1:0] load_tx,
    input  logic [6:0]         load_bits,
    input  logic               miso,
    output logic               sclk,
    output logic               mosi,
    output logic               frame_done,
    output logic [31:0]        rx_data
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic [6:0]         bit_cnt;
    logic [6:0]         frame_bits;
    logic [FRAME_W-1:0] tx_shift;
    logic               sclk_r;
    logic               phase_end;

    assign phase_end  = shift_en && (div_cnt == DIV_LAST);
    assign frame_done = phase_end && sclk_r && (bit_cnt == frame_bits - 7'd1);
    assign sclk       = sclk_r;
    assign mosi       = shift_en & tx_shift[FRAME_W-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            frame_bits <= 7'd64;
            tx_shift   <= '0;
            sclk_r     <= 1'b0;
            rx_data    <= '0;
        end else if (load) begin
            tx_shift   <= load_tx;
            frame_bits <= load_bits;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            sclk_r     <= 1'b0;
        end else if (shift_en) begin
            if (phase_end) begin
                div_cnt <= '0;
                sclk_r  <= ~sclk_r;
                if (!sclk_r) begin
                    rx_data <= {rx_data[30:0], miso};
                end else begin
                    // Falling edge: advance to the next bit for the slave.
                    tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
                    bit_cnt  <= bit_cnt + 7'd1;
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end else begin
            div_cnt <= '0;
            sclk_r  <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single SPI serial memory.
// Round-robin grant in IDLE, then one framed read or write per grant.
module spi_mem_arbiter
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [23:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [23:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    output logic        cs,
    input  logic        miso
);

    state_t             state, state_next;
    port_t              last_grant, cur_port, grant_port;
    logic               cur_we, grant_we, grant;
    logic [2:0]         cur_nbytes, grant_nbytes;
    logic [15:0]        wait_cnt;
    logic [FRAME_W-1:0] load_tx;
    logic [6:0]         load_bits;
    logic [31:0]        wdata_wire;
    logic [31:0]        rx_data;
    logic               frame_done;
    logic               shift_en;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        grant      = (state == ST_IDLE) && (if_req || ls_req);
        grant_port = PORT_FETCH;
        if (ls_req && (!if_req || last_grant == PORT_FETCH)) begin
            grant_port = PORT_LS;
        end
        grant_we     = (grant_port == PORT_LS) && ls_we;
        grant_nbytes = (grant_port == PORT_LS) ? size_to_bytes(ls_size) : 3'd4;
        load_bits    = 7'd32 + {1'b0, grant_nbytes, 3'b000};
        wdata_wire   = grant_we ? {ls_wdata[7:0], ls_wdata[15:8], ls_wdata[23:16], ls_wdata[31:24]}
                                : 32'h0;
        load_tx      = {grant_we ? CMD_WRITE : CMD_READ,
                        (grant_port == PORT_LS) ? ls_addr : if_addr,
                        wdata_wire};
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (if_req || ls_req) state_next = ST_CS_SETUP;
            ST_CS_SETUP: if (wait_cnt == 16'(CS_SETUP - 1)) state_next = ST_SHIFT;
            ST_SHIFT:    if (frame_done) state_next = ST_CS_HOLD;
            ST_CS_HOLD:  if (wait_cnt == 16'(CS_HOLD - 1)) state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            last_grant <= PORT_FETCH;
            cur_port   <= PORT_FETCH;
            cur_we     <= 1'b0;
            cur_nbytes <= 3'd4;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state_next != state) ? 16'd0 : wait_cnt + 16'd1;
            if (grant) begin
                cur_port   <= grant_port;
                last_grant <= grant_port;
                cur_we     <= grant_we;
                cur_nbytes <= grant_nbytes;
            end
            // Last miso sample is already in rx_data when the final fall ends the frame.
            if (frame_done && !cur_we) begin
                if (cur_port == PORT_FETCH) begin
                    if_rdata <= rx_to_le(rx_data, 3'd4);
                end else begin
                    ls_rdata <= rx_to_le(rx_data, cur_nbytes);
                end
            end
        end
    end

    assign shift_en = (state == ST_SHIFT);
    assign cs       = !((state == ST_CS_SETUP) || (state == ST_SHIFT) || (state == ST_CS_HOLD));
    assign busy     = (state != ST_IDLE);
    assign if_done  = (state == ST_DONE) && (cur_port == PORT_FETCH);
    assign ls_done  = (state == ST_DONE) && (cur_port == PORT_LS);

    spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (grant),
        .shift_en   (shift_en),
        .load_tx    (load_tx),
        .load_bits  (load_bits),
        .miso       (miso),
        .sclk       (sclk),
        .mosi       (mosi),
        .frame_done (frame_done),
        .rx_data    (rx_data)
    );

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: a vector table of single transactions
// against a simple SPI slave model, plus round-robin and mid-frame reset sequences.
module tb_spi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we;
    logic [23:0] if_addr, ls_addr;
    logic [1:0]  ls_size;
    logic [31:0] ls_wdata;
    logic [31:0] if_rdata, ls_rdata;
    logic        if_done, ls_done, busy, sclk, mosi, cs;
    logic        miso = 1'b0;

    always #5 clk = ~clk;

    spi_mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_size  (ls_size),
        .ls_wdata (ls_wdata),
        .ls_rdata (ls_rdata),
        .ls_done  (ls_done),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs       (cs),
        .miso     (miso)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: captures mosi on sclk rise, presents data byte bits after
    // each fall; drives 1s outside the data phase so unmasked lanes show up.
    logic [31:0] miso_word = 32'h0;
    logic [63:0] cap       = 64'h0;
    int          cap_cnt   = 0;
    int          fall_cnt  = 0;
    int          if_done_cnt = 0;
    int          ls_done_cnt = 0;
    logic        cs_q   = 1'b1;
    logic        sclk_q = 1'b0;

    always @(negedge clk) begin
        if (cs === 1'b0 && cs_q === 1'b1) begin
            fall_cnt = 0;
            cap      = 64'h0;
            cap_cnt  = 0;
        end
        if (cs === 1'b0) begin
            if (sclk && !sclk_q) begin
                cap = {cap[62:0], mosi};
                cap_cnt++;
            end
            if (!sclk && sclk_q) fall_cnt++;
            miso = (fall_cnt >= 32 && fall_cnt < 64) ? miso_word[63 - fall_cnt] : 1'b1;
        end else begin
            miso = 1'b0;
        end
        if (if_done === 1'b1) if_done_cnt++;
        if (ls_done === 1'b1) ls_done_cnt++;
        cs_q   = cs;
        sclk_q = sclk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [23:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] miso_word;
        logic [63:0] exp_frame;
        int          exp_bits;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_ls_rdata = 32'h0;

    task automatic run_vec(input vec_t v, input int idx);
        int start;
        int n_if0;
        int n_ls0;
        bit seen;
        miso_word = v.miso_word;
        if_addr   = v.addr;
        ls_addr   = v.addr;
        ls_we     = v.we;
        ls_size   = v.size;
        ls_wdata  = v.wdata;
        n_if0     = if_done_cnt;
        n_ls0     = ls_done_cnt;
        start     = cyc;
        if (v.is_ls) ls_req = 1'b1;
        else         if_req = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d busy_after_grant", idx), busy, 1);
        check($sformatf("v%0d cs_low_setup", idx), cs, 0);
        // Inputs after grant must be ignored.
        if_addr  = ~v.addr;
        ls_addr  = ~v.addr;
        ls_we    = ~v.we;
        ls_size  = ~v.size;
        ls_wdata = ~v.wdata;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = (if_done === 1'b1) || (ls_done === 1'b1);
        end
        check($sformatf("v%0d done_seen", idx), seen, 1);
        check($sformatf("v%0d latency", idx), cyc - start, v.exp_lat);
        check($sformatf("v%0d done_port", idx), {if_done, ls_done}, v.is_ls ? 2'b01 : 2'b10);
        if (!(v.is_ls && v.we)) begin
            if (v.is_ls) exp_ls_rdata = v.exp_rdata;
            else         exp_if_rdata = v.exp_rdata;
        end
        check($sformatf("v%0d if_rdata", idx), if_rdata, exp_if_rdata);
        check($sformatf("v%0d ls_rdata", idx), ls_rdata, exp_ls_rdata);
        @(negedge clk);
        if_req = 1'b0;
        ls_req = 1'b0;
        check($sformatf("v%0d busy_idle", idx), busy, 0);
        check($sformatf("v%0d cs_high_idle", idx), cs, 1);
        @(negedge clk);
        check($sformatf("v%0d no_regrant", idx), cs, 1);
        check($sformatf("v%0d if_done_count", idx), if_done_cnt - n_if0, v.is_ls ? 0 : 1);
        check($sformatf("v%0d ls_done_count", idx), ls_done_cnt - n_ls0, v.is_ls ? 1 : 0);
        check($sformatf("v%0d frame_bits", idx), cap, v.exp_frame);
        check($sformatf("v%0d frame_len", idx), cap_cnt, v.exp_bits);
    endtask

    initial begin
        int order[3];
        int n_done;
        int gap;
        int n_if0;
        int n_ls0;

        vecs[0] = '{1'b0, 1'b0, 24'h000100, 2'd0, 32'h0,        32'h11223344, 64'h03000100_00000000, 64, 32'h44332211, 265};
        vecs[1] = '{1'b1, 1'b1, 24'h00ABCD, 2'd0, 32'hDEADBEEF, 32'h0,        64'h00000002_00ABCDEF, 40, 32'h0,        169};
        vecs[2] = '{1'b1, 1'b0, 24'h001234, 2'd1, 32'h0,        32'h5AA50000, 64'h00000300_12340000, 48, 32'h0000A55A, 201};
        vecs[3] = '{1'b1, 1'b0, 24'hFFFFFF, 2'd2, 32'h0,        32'h01020304, 64'h03FFFFFF_00000000, 64, 32'h04030201, 265};
        vecs[4] = '{1'b1, 1'b1, 24'h800001, 2'd3, 32'h12345678, 32'h0,        64'h02800001_78563412, 64, 32'h0,        265};
        vecs[5] = '{1'b1, 1'b0, 24'h000003, 2'd0, 32'h0,        32'hC3000000, 64'h00000003_00000300, 40, 32'h000000C3, 169};
        vecs[6] = '{1'b0, 1'b0, 24'hFFFFFC, 2'd0, 32'h0,        32'hEFBEADDE, 64'h03FFFFFC_00000000, 64, 32'hDEADBEEF, 265};
        vecs[7] = '{1'b1, 1'b1, 24'h010203, 2'd1, 32'hAABBCCDD, 32'h0,        64'h00000201_0203DDCC, 48, 32'h0,        201};

        rst_n    = 1'b0;
        if_req   = 1'b0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        if_addr  = 24'h0;
        ls_addr  = 24'h0;
        ls_size  = 2'd0;
        ls_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset cs", cs, 1);
        check("reset sclk", sclk, 0);
        check("reset mosi", mosi, 0);
        check("reset busy", busy, 0);
        check("reset dones", {if_done, ls_done}, 2'b00);
        check("reset if_rdata", if_rdata, 0);
        check("reset ls_rdata", ls_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie right after reset: ls, fetch, ls with cs high two cycles between frames.
        miso_word = 32'h11223344;
        if_addr   = 24'h000200;
        ls_addr   = 24'h000300;
        ls_we     = 1'b1;
        ls_size   = 2'd0;
        ls_wdata  = 32'h000000A5;
        if_req    = 1'b1;
        ls_req    = 1'b1;
        n_done    = 0;
        for (int i = 0; i < 2000 && n_done < 3; i++) begin
            @(negedge clk);
            if (if_done === 1'b1 || ls_done === 1'b1) begin
                order[n_done] = (ls_done === 1'b1) ? 1 : 0;
                check($sformatf("rr done_one_port_%0d", n_done), if_done & ls_done, 0);
                n_done++;
                if (n_done == 3) begin
                    if_req = 1'b0;
                    ls_req = 1'b0;
                end else begin
                    gap = 1;
                    for (int j = 0; j < 10; j++) begin
                        @(negedge clk);
                        if (cs !== 1'b1) break;
                        gap++;
                    end
                    check($sformatf("rr cs_gap_%0d", n_done), gap, 2);
                end
            end
        end
        check("rr done_count", n_done, 3);
        check("rr order_0_ls", order[0], 1);
        check("rr order_1_if", order[1], 0);
        check("rr order_2_ls", order[2], 1);
        exp_if_rdata = 32'h44332211;
        check("rr if_rdata", if_rdata, exp_if_rdata);
        check("rr ls_rdata_write_untouched", ls_rdata, 0);
        repeat (2) @(negedge clk);

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Reset in the middle of a fetch frame.
        n_if0     = if_done_cnt;
        n_ls0     = ls_done_cnt;
        miso_word = 32'h99887766;
        if_addr   = 24'h000400;
        if_req    = 1'b1;
        repeat (60) @(negedge clk);
        check("rst_mid cs_low_before", cs, 0);
        rst_n = 1'b0;
        @(negedge clk);
        if_req = 1'b0;
        check("rst_mid cs", cs, 1);
        check("rst_mid sclk", sclk, 0);
        check("rst_mid mosi", mosi, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid if_rdata", if_rdata, 0);
        check("rst_mid ls_rdata", ls_rdata, 0);
        exp_if_rdata = 32'h0;
        exp_ls_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("rst_mid no_if_done", if_done_cnt - n_if0, 0);
        check("rst_mid no_ls_done", ls_done_cnt - n_ls0, 0);
        check("rst_mid idle_cs", cs, 1);
        run_vec(vecs[0], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
